// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// a small helper for the saturating fill level.
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Fill saturates at the register length; callers pass both in a 32-bit
  // container and truncate the result to their own fill width.
  function automatic int unsigned fill_step(input int unsigned cur,
                                            input int unsigned limit);
    if (cur >= limit) begin
      return limit;
    end
    return cur + 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// W-bit up counter with synchronous clear that sticks at all-ones instead of
// wrapping. Clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_nxt;
  logic         at_max;

  assign at_max = (cnt == {W{1'b1}});

  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (inc && !at_max) begin
      cnt_nxt = cnt + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register (hold / shift right / shift left / load)
// with fill tracking, masked pattern compare and a saturating hit counter.
module universal_shift_register
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   mode,
  input  logic                         inp,
  input  logic [WIDTH-1:0]             par_in,
  input  logic [WIDTH-1:0]             pattern,
  input  logic [WIDTH-1:0]             mask,
  input  logic                         clr_cnt,
  output logic [WIDTH-1:0]             q,
  output logic                         outp,
  output logic [$clog2(WIDTH+1)-1:0]   fill,
  output logic                         full,
  output logic                         match,
  output logic [CNT_W-1:0]             match_cnt
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(WIDTH);

  logic [WIDTH-1:0] q_nxt;
  logic [FW-1:0]    fill_nxt;
  logic [FW-1:0]    fill_inc;
  logic             cnt_inc;

  // fill counts bits received, not where they sit, so either shift direction
  // advances it the same way.
  assign fill_inc = FW'(fill_step(32'(fill), 32'(WIDTH)));

  always_comb begin
    q_nxt    = q;
    fill_nxt = fill;
    unique case (mode)
      MODE_SHR: begin
        q_nxt    = {inp, q[WIDTH-1:1]};
        fill_nxt = fill_inc;
      end
      MODE_SHL: begin
        q_nxt    = {q[WIDTH-2:0], inp};
        fill_nxt = fill_inc;
      end
      MODE_LOAD: begin
        q_nxt    = par_in;
        fill_nxt = FILL_MAX;
      end
      default: begin
        q_nxt    = q;
        fill_nxt = fill;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      fill <= '0;
    end else begin
      q    <= q_nxt;
      fill <= fill_nxt;
    end
  end

  // Serial output follows the shift direction; it tracks mode immediately.
  assign outp  = (mode == MODE_SHL) ? q[WIDTH-1] : q[0];
  assign full  = (fill == FILL_MAX);
  assign match = full && (((q ^ pattern) & mask) == '0);

  // Hold edges never count, so a parked matching state scores at most once.
  assign cnt_inc = (mode != MODE_HOLD) && match;

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk(clk),
    .rst(rst),
    .clr(clr_cnt),
    .inc(cnt_inc),
    .cnt(match_cnt)
  );

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register: three instances cover the
// legacy/pattern case (W=4), left shift and fill/reset (W=8), and saturation.
module tb_universal_shift_register;

  logic clk;

  // Instance A: WIDTH=4, CNT_W=8
  logic       a_rst, a_inp, a_clr, a_outp, a_full, a_match;
  logic [1:0] a_mode;
  logic [3:0] a_par, a_pat, a_mask, a_q;
  logic [2:0] a_fill;
  logic [7:0] a_cnt;

  // Instance B: WIDTH=8, CNT_W=8
  logic       b_rst, b_inp, b_clr, b_outp, b_full, b_match;
  logic [1:0] b_mode;
  logic [7:0] b_par, b_pat, b_mask, b_q;
  logic [3:0] b_fill;
  logic [7:0] b_cnt;

  // Instance C: WIDTH=4, CNT_W=2
  logic       c_rst, c_inp, c_clr, c_outp, c_full, c_match;
  logic [1:0] c_mode;
  logic [3:0] c_par, c_pat, c_mask, c_q;
  logic [2:0] c_fill;
  logic [1:0] c_cnt;

  int errors = 0;
  int checks = 0;

  logic [0:0] exp_q[$];

  universal_shift_register #(.WIDTH(4), .CNT_W(8)) u_a (
    .clk(clk), .rst(a_rst), .mode(a_mode), .inp(a_inp), .par_in(a_par),
    .pattern(a_pat), .mask(a_mask), .clr_cnt(a_clr), .q(a_q), .outp(a_outp),
    .fill(a_fill), .full(a_full), .match(a_match), .match_cnt(a_cnt)
  );

  universal_shift_register #(.WIDTH(8), .CNT_W(8)) u_b (
    .clk(clk), .rst(b_rst), .mode(b_mode), .inp(b_inp), .par_in(b_par),
    .pattern(b_pat), .mask(b_mask), .clr_cnt(b_clr), .q(b_q), .outp(b_outp),
    .fill(b_fill), .full(b_full), .match(b_match), .match_cnt(b_cnt)
  );

  universal_shift_register #(.WIDTH(4), .CNT_W(2)) u_c (
    .clk(clk), .rst(c_rst), .mode(c_mode), .inp(c_inp), .par_in(c_par),
    .pattern(c_pat), .mask(c_mask), .clr_cnt(c_clr), .q(c_q), .outp(c_outp),
    .fill(c_fill), .full(c_full), .match(c_match), .match_cnt(c_cnt)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish (got running, need done)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] stream;
    logic [7:0]  pstream;
    logic [3:0]  mq;
    logic        front;

    stream  = 16'b0101111100001010;
    pstream = 8'b10101010;

    a_rst = 1'b1; a_mode = 2'b00; a_inp = 1'b0; a_clr = 1'b0;
    a_par = '0; a_pat = 4'b1010; a_mask = 4'b1111;
    b_rst = 1'b1; b_mode = 2'b00; b_inp = 1'b0; b_clr = 1'b0;
    b_par = '0; b_pat = '0; b_mask = '0;
    c_rst = 1'b1; c_mode = 2'b00; c_inp = 1'b0; c_clr = 1'b0;
    c_par = '0; c_pat = '0; c_mask = '0;

    tick();
    tick();
    check("rst_a_q", 64'(a_q), 64'h0);
    check("rst_a_fill", 64'(a_fill), 64'd0);
    check("rst_a_full", 64'(a_full), 64'd0);
    check("rst_a_match", 64'(a_match), 64'd0);
    check("rst_a_cnt", 64'(a_cnt), 64'd0);
    check("rst_a_outp", 64'(a_outp), 64'd0);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    // Legacy equivalence: right shift, outp delayed by 4 edges
    a_mode = 2'b01;
    mq = '0;
    for (int k = 0; k < 16; k++) begin
      a_inp = stream[k];
      tick();
      mq = {stream[k], mq[3:1]};
      exp_q.push_back(stream[k]);
      if (k == 3) begin
        check("legacy_q4", 64'(a_q), 64'b1010);
        check("legacy_fill4", 64'(a_fill), 64'd4);
        check("legacy_full4", 64'(a_full), 64'd1);
      end
      if (k == 2) check("legacy_full3", 64'(a_full), 64'd0);
      if (exp_q.size() == 4) begin
        front = exp_q.pop_front();
        check($sformatf("legacy_outp_%0d", k), 64'(a_outp), 64'(front));
      end
    end
    check("legacy_q_end", 64'(a_q), 64'(mq));

    // Pattern count on A
    a_mode = 2'b00;
    a_rst = 1'b1;
    #1;
    a_rst = 1'b0;
    check("pat_rst_cnt", 64'(a_cnt), 64'd0);
    a_mode = 2'b01;
    for (int k = 0; k < 8; k++) begin
      a_inp = pstream[k];
      tick();
      if (k == 2) check("pat_match_fill3", 64'(a_match), 64'd0);
      if (k == 3) begin
        check("pat_match_fill4", 64'(a_match), 64'd1);
        check("pat_cnt_fill4", 64'(a_cnt), 64'd0);
      end
      if (k == 4) check("pat_match_fill5", 64'(a_match), 64'd0);
      if (k == 4) check("pat_cnt_fill5", 64'(a_cnt), 64'd1);
    end
    check("pat_cnt_end", 64'(a_cnt), 64'd2);
    check("pat_match_end", 64'(a_match), 64'd1);
    a_mode = 2'b00;
    for (int k = 0; k < 5; k++) tick();
    check("pat_cnt_hold", 64'(a_cnt), 64'd2);
    a_mode = 2'b01; a_inp = 1'b0;
    tick();
    check("pat_cnt_leave", 64'(a_cnt), 64'd3);
    a_mode = 2'b00;

    // Saturation on C (CNT_W=2, mask=0)
    c_mode = 2'b11; c_par = 4'h9;
    tick();
    check("sat_load_q", 64'(c_q), 64'h9);
    check("sat_load_full", 64'(c_full), 64'd1);
    check("sat_load_match", 64'(c_match), 64'd1);
    check("sat_load_cnt", 64'(c_cnt), 64'd0);
    c_mode = 2'b01; c_inp = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 2) check("sat_cnt3", 64'(c_cnt), 64'd3);
    end
    check("sat_cnt_stick", 64'(c_cnt), 64'd3);
    c_clr = 1'b1;
    tick();
    check("sat_clr_on_count", 64'(c_cnt), 64'd0);
    c_clr = 1'b0;
    tick();
    check("sat_after_clr", 64'(c_cnt), 64'd1);
    c_mode = 2'b00;

    // Fill, left shift and async reset on B (mask=0)
    b_mode = 2'b01; b_inp = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("fill5_q", 64'(b_q), 64'hF8);
    check("fill5_fill", 64'(b_fill), 64'd5);
    check("fill5_full", 64'(b_full), 64'd0);
    check("fill5_match", 64'(b_match), 64'd0);
    b_mode = 2'b11; b_par = 8'hA5;
    tick();
    check("load_q", 64'(b_q), 64'hA5);
    check("load_fill", 64'(b_fill), 64'd8);
    check("load_cnt", 64'(b_cnt), 64'd0);
    b_mode = 2'b10; b_inp = 1'b1;
    tick();
    check("shl1_q", 64'(b_q), 64'h4B);
    check("shl1_outp", 64'(b_outp), 64'd0);
    tick();
    check("shl2_q", 64'(b_q), 64'h97);
    check("shl2_outp", 64'(b_outp), 64'd1);
    tick();
    check("shl3_q", 64'(b_q), 64'h2F);
    check("shl3_outp", 64'(b_outp), 64'd0);
    check("shl3_cnt", 64'(b_cnt), 64'd3);
    check("shl3_fill", 64'(b_fill), 64'd8);
    b_mode = 2'b00;
    #1;
    check("hold_outp_src", 64'(b_outp), 64'd1);

    // Async reset between edges
    @(posedge clk);
    #2;
    b_rst = 1'b1;
    #1;
    check("arst_q", 64'(b_q), 64'h0);
    check("arst_fill", 64'(b_fill), 64'd0);
    check("arst_full", 64'(b_full), 64'd0);
    check("arst_cnt", 64'(b_cnt), 64'd0);
    check("arst_outp", 64'(b_outp), 64'd0);
    b_rst = 1'b0;
    b_mode = 2'b11; b_par = 8'h3C;
    tick();
    check("post_rst_load_q", 64'(b_q), 64'h3C);
    check("post_rst_load_fill", 64'(b_fill), 64'd8);
    check("post_rst_load_full", 64'(b_full), 64'd1);
    b_mode = 2'b00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised successor to the fixed 4-stage serial shift register: a WIDTH-bit universal shift register with hold, shift-right, shift-left and parallel-load modes. It also tracks fill level, compares its contents against a masked pattern, and counts pattern hits. It serves as the serial-to-parallel / parallel-to-serial and sequence-detect stage in the datapath. With WIDTH=4 and mode fixed to shift-right, it is a drop-in for the legacy 4-stage serial delay.

## Interface
- WIDTH, 4, register length in bits; legal range 2..64
- CNT_W, 8, width of the match counter
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous and active-high
- mode  in  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load
- inp  in  1  serial input bit for either shift direction
- par_in  in  WIDTH  parallel load data
- pattern  in  WIDTH  compare pattern
- mask  in  WIDTH  compare mask; 1 = bit participates
- clr_cnt  in  1  synchronous clear of match_cnt
- q  out  WIDTH  register contents
- outp  out  1  serial output: q[0] unless mode=10, then q[WIDTH-1] (combinational from q and mode)
- fill  out  $clog2(WIDTH+1)  number of valid bits held, saturating at WIDTH
- full  out  1  fill == WIDTH
- match  out  1  full && (((q ^ pattern) & mask) == 0), combinational from state
- match_cnt  out  CNT_W  saturating count of matches

## Operation
- Shift right (01): q <= {inp, q[WIDTH-1:1]}; fill <= min(fill+1, WIDTH).
- Shift left (10): q <= {q[WIDTH-2:0], inp}; fill <= min(fill+1, WIDTH).
- Parallel load (11): q <= par_in; fill <= WIDTH.
- Hold (00): q and fill unchanged.
- match_cnt, evaluated at each rising edge, in priority order:
  - clr_cnt=1 → 0.
  - else if mode≠00 and match=1 (pre-edge value) → +1, saturating at 2^CNT_W−1; no wrap.
  - else unchanged.
- A hold cycle never counts, so a matching state held for many cycles counts at most once, on the edge that leaves it.
- mask=0 with full=1 makes match=1 for every state.
- Changing direction mid-stream is legal. fill keeps incrementing; it tracks bits received, not their position.
- Reset values: q=0, fill=0, full=0, match=0, match_cnt=0, outp=0.

## Timing
- Register update latency is one edge for every mode.
- Serial delay in mode 01: a bit presented on inp at edge n appears on outp after edge n+WIDTH-1 has updated q. That is WIDTH edges of flight, the same as the legacy 4-stage block at WIDTH=4.
- outp, full and match are glitch-free functions of registered state plus mode. outp switches source immediately when mode changes.
- Async reset mid-operation clears all state immediately, regardless of clk. The first edge after rst deasserts performs the requested mode from an all-zero, fill=0 state.
- clr_cnt coinciding with a counted match leaves the counter at 0.
- fill saturation: the shift that brings fill from WIDTH-1 to WIDTH asserts full in the following cycle. A parallel load asserts full in the next cycle from any fill level.

## Structure
- Shared package shift_reg_pkg holds the mode encodings as localparams: MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
- One sub-module is natural: sat_counter (parameter W; inputs clk, rst, clr, inc; output cnt), used for match_cnt. The fill counter is inline because of its load-to-max path.
- No other hierarchy.

## Test plan
- Legacy equivalence: WIDTH=4, rst pulse, then mode=01 and shift in 0,1,0,1 on four edges. Expect q=4'b1010, outp=0, fill=4, full=1. Continue with the rest of 16'b0101111100001010; outp must reproduce the stream delayed by 4 edges.
- Left shift / direction: WIDTH=8, load 8'hA5, mode=10 with inp=1 for 3 edges. Expect q=8'h2F; outp=q[7] during mode 10; outp=q[0] as soon as mode switches to 00.
- Pattern count: WIDTH=4, pattern=4'b1010, mask=4'b1111, right-shift the stream 1010 1010. Matches occur at fill=4 and every 2 shifts after. Expect match_cnt=2 after the final edge; holding the matching state for 5 cycles adds 0.
- Saturation: CNT_W=2, mask=0, load then 6 shifts. Expect match_cnt to stick at 3. Assert clr_cnt on a counting edge: expect 0.
- Fill and reset: WIDTH=8, shift 5 bits → fill=5, full=0. Assert rst asynchronously between edges: expect q=0, fill=0, match_cnt=0 before the next edge. Then one load → fill=8, full=1.
